// File: rtl/lfsr_sequence_checker.sv
// -----------------------------------------------------------------------------
// lfsr_sequence_checker
//
// Monitors the state words of a 6-bit Type 1 (Fibonacci) LFSR built on
// x^6 + x^5 + 1. Each valid word is compared with a prediction made from
// the previous word. The checker locks onto the stream and counts mispredictions
// while locked. It also measures the sequence period in valid samples.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous, active-high reset
//   valid_in     data_in carries a new LFSR state this cycle
//   data_in      LFSR state word, bit 5 = stage 6 (MSB)
//   clear        synchronous: zero err_count/period/period_valid, back to HUNT
//   locked       checker is synchronised to the stream
//   err_pulse    one-cycle pulse per mispredicted sample while locked
//   err_count    saturating count of mispredictions while locked
//   period       last measured sequence length, in valid samples
//   period_valid period holds a completed measurement
//
// Parameters:
//   DEBRUIJN     1: all-zero state is part of the sequence (period 64)
//                0: pure maximal-length sequence (period 63), zero is illegal
//   LOCK_COUNT   consecutive correct predictions needed to lock (1..15)
//   MISS_LIMIT   consecutive mispredictions that drop lock (1..15)
//   ERR_W        width of the saturating error counter
// -----------------------------------------------------------------------------
module lfsr_sequence_checker #(
    parameter int DEBRUIJN   = 1,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [5:0]       data_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [6:0]       period,
    output logic             period_valid
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] MISS_CNT = 4'(MISS_LIMIT);
    localparam logic [6:0] PER_MAX  = 7'h7F;

    // Successor of a state word. Bits [5:0] hold stages 6..1. In De Bruijn
    // mode the extra NOR term splices the all-zero word in after 6'h20.
    function automatic logic [5:0] lfsr_next(input logic [5:0] s);
        logic fb;
        fb = s[5] ^ s[4];
        if (DEBRUIJN != 0) begin
            fb = fb ^ ~(|s[4:0]);
        end
        return {s[4:0], fb};
    endfunction

    logic [1:0]       r_state;
    logic [5:0]       r_pred;
    logic [3:0]       r_match_cnt;
    logic [3:0]       r_miss_cnt;
    logic [ERR_W-1:0] r_err_count;
    logic             r_err_pulse;
    logic [6:0]       r_period;
    logic             r_period_valid;
    logic [6:0]       r_per_cnt;
    logic [5:0]       r_ref;
    logic             r_meas_active;

    logic [5:0]       w_pred_data;
    logic [5:0]       w_pred_fly;
    logic             w_match;
    logic             w_zero_illegal;
    logic             w_err_sat;

    assign w_pred_data    = lfsr_next(data_in);
    assign w_pred_fly     = lfsr_next(r_pred);
    assign w_match        = (data_in == r_pred);
    assign w_zero_illegal = (DEBRUIJN == 0) && (data_in == 6'h00);
    assign w_err_sat      = &r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_HUNT;
            r_pred         <= 6'h00;
            r_match_cnt    <= 4'd0;
            r_miss_cnt     <= 4'd0;
            r_err_count    <= '0;
            r_err_pulse    <= 1'b0;
            r_period       <= 7'd0;
            r_period_valid <= 1'b0;
            r_per_cnt      <= 7'd0;
            r_ref          <= 6'h00;
            r_meas_active  <= 1'b0;
        end else if (clear) begin
            // Any sample presented together with clear is discarded.
            r_state        <= ST_HUNT;
            r_match_cnt    <= 4'd0;
            r_miss_cnt     <= 4'd0;
            r_err_count    <= '0;
            r_err_pulse    <= 1'b0;
            r_period       <= 7'd0;
            r_period_valid <= 1'b0;
            r_per_cnt      <= 7'd0;
            r_meas_active  <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (valid_in) begin
                case (r_state)
                    ST_HUNT: begin
                        if (!w_zero_illegal) begin
                            r_pred      <= w_pred_data;
                            r_match_cnt <= 4'd0;
                            r_state     <= ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        // Both outcomes reseed from the incoming word. Only
                        // the run length of matches decides locking.
                        r_pred <= w_pred_data;
                        if (w_match) begin
                            if (r_match_cnt + 4'd1 == LOCK_CNT) begin
                                r_state       <= ST_LOCKED;
                                r_match_cnt   <= 4'd0;
                                r_miss_cnt    <= 4'd0;
                                r_meas_active <= 1'b0;
                            end else begin
                                r_match_cnt <= r_match_cnt + 4'd1;
                            end
                        end else begin
                            r_match_cnt <= 4'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_match) begin
                            r_pred     <= w_pred_data;
                            r_miss_cnt <= 4'd0;
                            // The first good sample without a live measurement
                            // becomes the reference word. Its recurrence closes
                            // one period.
                            if (!r_meas_active) begin
                                r_ref         <= data_in;
                                r_per_cnt     <= 7'd1;
                                r_meas_active <= 1'b1;
                            end else if (data_in == r_ref) begin
                                r_period       <= r_per_cnt;
                                r_period_valid <= 1'b1;
                                r_per_cnt      <= 7'd1;
                            end else if (r_per_cnt != PER_MAX) begin
                                r_per_cnt <= r_per_cnt + 7'd1;
                            end
                        end else begin
                            r_err_pulse <= 1'b1;
                            if (!w_err_sat) begin
                                r_err_count <= r_err_count + ERR_W'(1);
                            end
                            // Flywheel: advance from our own prediction so the
                            // bad word cannot derail the following compares.
                            r_pred        <= w_pred_fly;
                            r_meas_active <= 1'b0;
                            if (r_miss_cnt + 4'd1 == MISS_CNT) begin
                                r_state    <= ST_HUNT;
                                r_miss_cnt <= 4'd0;
                            end else begin
                                r_miss_cnt <= r_miss_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign locked       = (r_state == ST_LOCKED);
    assign err_pulse    = r_err_pulse;
    assign err_count    = r_err_count;
    assign period       = r_period;
    assign period_valid = r_period_valid;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for lfsr_sequence_checker.
// Three instances are used:
//   0: DEBRUIJN=1, ERR_W=16
//   1: DEBRUIJN=0, ERR_W=16
//   2: DEBRUIJN=1, ERR_W=2
// The reference model predicts the successor of a word by its position in a
// precomputed sequence table. It does not evaluate the feedback equation.
// -----------------------------------------------------------------------------
module tb_lfsr_sequence_checker;

    localparam int LOCK = 4;
    localparam int MISS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] v;
    logic [2:0] c;
    logic [5:0] d [3];

    wire [2:0]  lk;
    wire [2:0]  ep;
    wire [2:0]  pv;
    wire [6:0]  per0, per1, per2;
    wire [15:0] ec0, ec1;
    wire [1:0]  ec2;

    always #5 clk = ~clk;

    lfsr_sequence_checker #(.DEBRUIJN(1), .LOCK_COUNT(LOCK), .MISS_LIMIT(MISS), .ERR_W(16)) dut0 (
        .clk(clk), .reset(reset), .valid_in(v[0]), .data_in(d[0]), .clear(c[0]),
        .locked(lk[0]), .err_pulse(ep[0]), .err_count(ec0), .period(per0), .period_valid(pv[0]));
    lfsr_sequence_checker #(.DEBRUIJN(0), .LOCK_COUNT(LOCK), .MISS_LIMIT(MISS), .ERR_W(16)) dut1 (
        .clk(clk), .reset(reset), .valid_in(v[1]), .data_in(d[1]), .clear(c[1]),
        .locked(lk[1]), .err_pulse(ep[1]), .err_count(ec1), .period(per1), .period_valid(pv[1]));
    lfsr_sequence_checker #(.DEBRUIJN(1), .LOCK_COUNT(LOCK), .MISS_LIMIT(MISS), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .valid_in(v[2]), .data_in(d[2]), .clear(c[2]),
        .locked(lk[2]), .err_pulse(ep[2]), .err_count(ec2), .period(per2), .period_valid(pv[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- sequence tables ----------------
    logic [5:0] seq_t [2][64];
    int         pos_t [2][64];
    int         len_t [2];
    int         P_DB     [3] = '{1, 0, 1};
    int         P_ERRMAX [3] = '{65535, 65535, 3};

    function automatic void build_tables();
        logic [5:0] s;
        int n1;
        s  = 6'h01;
        n1 = 0;
        for (int i = 0; i < 63; i++) begin
            seq_t[0][i]  = s;
            seq_t[1][n1] = s;
            n1++;
            // De Bruijn extension: the zero word follows 100000.
            if (s == 6'h20) begin
                seq_t[1][n1] = 6'h00;
                n1++;
            end
            s = {s[4:0], s[5] ^ s[4]};
        end
        len_t[0] = 63;
        len_t[1] = 64;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 64; i++) pos_t[t][i] = -1;
            for (int i = 0; i < len_t[t]; i++) pos_t[t][seq_t[t][i]] = i;
        end
    endfunction

    function automatic logic [5:0] tnext(int k, logic [5:0] s);
        int t;
        t = P_DB[k];
        if (pos_t[t][s] < 0) return 6'h00;  // zero outside the m-sequence maps to itself
        return seq_t[t][(pos_t[t][s] + 1) % len_t[t]];
    endfunction

    // ---------------- reference model ----------------
    int         m_mode  [3];   // 0 hunt, 1 verify, 2 locked
    int         m_match [3];
    int         m_miss  [3];
    int         m_err   [3];
    int         m_period[3];
    int         m_cnt   [3];
    bit         m_pulse [3];
    bit         m_pval  [3];
    bit         m_meas  [3];
    logic [5:0] m_pred  [3];
    logic [5:0] m_ref   [3];
    logic [5:0] cur     [3];

    function automatic void m_reset(int k);
        m_mode[k] = 0; m_match[k] = 0; m_miss[k] = 0; m_err[k] = 0;
        m_period[k] = 0; m_cnt[k] = 0; m_pulse[k] = 0; m_pval[k] = 0;
        m_meas[k] = 0; m_pred[k] = 6'h00; m_ref[k] = 6'h00;
    endfunction

    function automatic void m_step(int k, bit vv, logic [5:0] dd, bit cc);
        m_pulse[k] = 0;
        if (cc) begin
            m_mode[k] = 0; m_match[k] = 0; m_miss[k] = 0; m_err[k] = 0;
            m_period[k] = 0; m_pval[k] = 0; m_meas[k] = 0;
            return;
        end
        if (!vv) return;
        case (m_mode[k])
            0: if (!(P_DB[k] == 0 && dd == 6'h00)) begin
                   m_pred[k] = tnext(k, dd); m_match[k] = 0; m_mode[k] = 1;
               end
            1: begin
                   if (dd == m_pred[k]) begin
                       m_match[k]++;
                       if (m_match[k] == LOCK) begin
                           m_mode[k] = 2; m_miss[k] = 0; m_meas[k] = 0;
                       end
                   end else begin
                       m_match[k] = 0;
                   end
                   m_pred[k] = tnext(k, dd);
               end
            default: begin
                   if (dd == m_pred[k]) begin
                       m_pred[k] = tnext(k, dd); m_miss[k] = 0;
                       if (!m_meas[k]) begin
                           m_ref[k] = dd; m_cnt[k] = 1; m_meas[k] = 1;
                       end else if (dd == m_ref[k]) begin
                           m_period[k] = m_cnt[k]; m_pval[k] = 1; m_cnt[k] = 1;
                       end else begin
                           m_cnt[k] = (m_cnt[k] >= 127) ? 127 : m_cnt[k] + 1;
                       end
                   end else begin
                       m_pulse[k] = 1;
                       if (m_err[k] < P_ERRMAX[k]) m_err[k]++;
                       m_pred[k] = tnext(k, m_pred[k]);
                       m_meas[k] = 0;
                       m_miss[k]++;
                       if (m_miss[k] == MISS) begin
                           m_mode[k] = 0; m_miss[k] = 0; m_match[k] = 0;
                       end
                   end
               end
        endcase
    endfunction

    // ---------------- helpers ----------------
    function automatic int ec_of(int k);
        case (k)
            0:       return int'(ec0);
            1:       return int'(ec1);
            default: return int'(ec2);
        endcase
    endfunction

    function automatic int per_of(int k);
        case (k)
            0:       return int'(per0);
            1:       return int'(per1);
            default: return int'(per2);
        endcase
    endfunction

    task automatic cmp(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(int k, string tag);
        cmp($sformatf("%s.locked%0d", tag, k),       int'(lk[k]), (m_mode[k] == 2) ? 1 : 0);
        cmp($sformatf("%s.err_pulse%0d", tag, k),    int'(ep[k]), int'(m_pulse[k]));
        cmp($sformatf("%s.err_count%0d", tag, k),    ec_of(k),    m_err[k]);
        cmp($sformatf("%s.period%0d", tag, k),       per_of(k),   m_period[k]);
        cmp($sformatf("%s.period_valid%0d", tag, k), int'(pv[k]), int'(m_pval[k]));
    endtask

    // One sample into instance k; outputs settle 1 ns after the edge.
    task automatic step(int k, bit vv, logic [5:0] dd, bit cc);
        v[k] = vv; d[k] = dd; c[k] = cc;
        @(posedge clk);
        #1;
        m_step(k, vv, dd, cc);
        v[k] = 1'b0; c[k] = 1'b0;
    endtask

    task automatic good(int k, int n, string tag);
        for (int i = 0; i < n; i++) begin
            step(k, 1'b1, cur[k], 1'b0);
            check_inst(k, tag);
            cur[k] = tnext(k, cur[k]);
        end
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset(string tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("%s.rst_locked%0d", tag, k),    int'(lk[k]), 0);
            cmp($sformatf("%s.rst_err_pulse%0d", tag, k), int'(ep[k]), 0);
            cmp($sformatf("%s.rst_err_count%0d", tag, k), ec_of(k),    0);
            cmp($sformatf("%s.rst_period%0d", tag, k),    per_of(k),   0);
            cmp($sformatf("%s.rst_pval%0d", tag, k),      int'(pv[k]), 0);
            m_reset(k);
            cur[k] = 6'h01;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         vv;
        logic [5:0] dd;
        bit         cc;
        bit         e_lk;
        bit         e_ep;
        int         e_ec;
    } vec_t;

    vec_t tbl [13];

    task automatic set_vec(int i, bit vv, logic [5:0] dd, bit cc, bit elk, bit eep, int eec);
        tbl[i].vv = vv; tbl[i].dd = dd; tbl[i].cc = cc;
        tbl[i].e_lk = elk; tbl[i].e_ep = eep; tbl[i].e_ec = eec;
    endtask

    initial begin
        int pulses;
        int nvalid;
        bit vv;
        bit cc;
        logic [5:0] dd;

        reset = 1'b1;
        v = 3'b000;
        c = 3'b000;
        for (int k = 0; k < 3; k++) d[k] = 6'h00;
        build_tables();

        // ---- directed table on instance 0 ----
        set_vec(0,  1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 0);
        set_vec(1,  1'b1, 6'h02, 1'b0, 1'b0, 1'b0, 0);
        set_vec(2,  1'b1, 6'h04, 1'b0, 1'b0, 1'b0, 0);
        set_vec(3,  1'b1, 6'h08, 1'b0, 1'b0, 1'b0, 0);
        set_vec(4,  1'b1, 6'h10, 1'b0, 1'b1, 1'b0, 0);  // 4th match -> locked
        set_vec(5,  1'b1, 6'h21, 1'b0, 1'b1, 1'b0, 0);
        set_vec(6,  1'b0, 6'h3F, 1'b0, 1'b1, 1'b0, 0);  // not valid: ignored
        set_vec(7,  1'b1, 6'h3F, 1'b0, 1'b1, 1'b1, 1);  // expected 03
        set_vec(8,  1'b1, 6'h06, 1'b0, 1'b1, 1'b0, 1);  // flywheel accepts 06
        set_vec(9,  1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1);
        set_vec(10, 1'b1, 6'h0C, 1'b1, 1'b0, 1'b0, 0);  // clear wins over sample
        set_vec(11, 1'b1, 6'h0C, 1'b0, 1'b0, 1'b0, 0);
        set_vec(12, 1'b1, 6'h18, 1'b0, 1'b0, 1'b0, 0);

        do_reset("init");
        for (int i = 0; i < 13; i++) begin
            step(0, tbl[i].vv, tbl[i].dd, tbl[i].cc);
            $display("vec %0d: v=%0d d=%h clr=%0d -> locked=%0d err_pulse=%0d err_count=%0d",
                     i, tbl[i].vv, tbl[i].dd, tbl[i].cc, lk[0], ep[0], ec0);
            cmp($sformatf("vec%0d.locked", i),    int'(lk[0]), int'(tbl[i].e_lk));
            cmp($sformatf("vec%0d.err_pulse", i), int'(ep[0]), int'(tbl[i].e_ep));
            cmp($sformatf("vec%0d.err_count", i), int'(ec0),   tbl[i].e_ec);
            cmp($sformatf("vec%0d.pval", i),      int'(pv[0]), 0);
        end

        // ---- De Bruijn lock and period 64, then single/triple corruption ----
        do_reset("s1");
        good(0, 5, "s1");
        cmp("s1.locked_after5", int'(lk[0]), 1);
        good(0, 65, "s1");
        cmp("s1.period", int'(per0), 64);
        cmp("s1.pval", int'(pv[0]), 1);
        cmp("s1.err_count", int'(ec0), 0);

        step(0, 1'b1, (cur[0] == 6'h3F) ? 6'h00 : 6'h3F, 1'b0);
        check_inst(0, "s3");
        cmp("s3.err_pulse", int'(ep[0]), 1);
        cmp("s3.err_count", int'(ec0), 1);
        cmp("s3.locked", int'(lk[0]), 1);
        cur[0] = tnext(0, cur[0]);
        good(0, 1, "s3");
        cmp("s3.pulse_one_cycle", int'(ep[0]), 0);
        cmp("s3.locked_held", int'(lk[0]), 1);

        for (int i = 0; i < 3; i++) begin
            step(0, 1'b1, cur[0] ^ 6'h15, 1'b0);
            check_inst(0, "s4");
            cur[0] = tnext(0, cur[0]);
        end
        cmp("s4.err_count", int'(ec0), 4);
        cmp("s4.unlocked", int'(lk[0]), 0);
        good(0, LOCK, "s4");
        cmp("s4.not_yet", int'(lk[0]), 0);
        good(0, 1, "s4");
        cmp("s4.relock", int'(lk[0]), 1);

        // ---- maximal-length: zero ignored in HUNT, period 63 ----
        do_reset("s2");
        step(1, 1'b1, 6'h00, 1'b0);
        check_inst(1, "s2");
        good(1, 70, "s2");
        cmp("s2.period", int'(per1), 63);
        cmp("s2.pval", int'(pv[1]), 1);

        // ---- irregular valid over a good stream ----
        do_reset("s5");
        pulses = 0;
        nvalid = 0;
        while (nvalid < 72) begin
            vv = ($urandom_range(0, 2) != 0);
            step(0, vv, vv ? cur[0] : 6'($urandom), 1'b0);
            check_inst(0, "s5");
            pulses += int'(ep[0]);
            if (vv) begin
                cur[0] = tnext(0, cur[0]);
                nvalid++;
            end
        end
        cmp("s5.period", int'(per0), 64);
        cmp("s5.pulses", pulses, 0);

        // ---- ERR_W=2 saturation, clear, mid-stream reset ----
        do_reset("s6");
        good(2, 75, "s6");
        pulses = 0;
        for (int e = 0; e < 5; e++) begin
            step(2, 1'b1, cur[2] ^ 6'h2A, 1'b0);
            check_inst(2, "s6");
            pulses += int'(ep[2]);
            cur[2] = tnext(2, cur[2]);
            good(2, 2, "s6");
        end
        cmp("s6.pulses", pulses, 5);
        cmp("s6.err_sat", int'(ec2), 3);
        cmp("s6.pval_before_clear", int'(pv[2]), 1);
        step(2, 1'b0, 6'h00, 1'b1);
        check_inst(2, "s6clr");
        cmp("s6.clr_err", int'(ec2), 0);
        cmp("s6.clr_pval", int'(pv[2]), 0);
        cmp("s6.clr_locked", int'(lk[2]), 0);
        good(2, 20, "s6");
        do_reset("s6rst");

        // ---- randomized stream with errors, gaps and clears ----
        for (int k = 0; k < 3; k++) begin
            do_reset("rnd");
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 99) == 0)
                    cur[k] = seq_t[P_DB[k]][$urandom_range(0, len_t[P_DB[k]] - 1)];
                vv = ($urandom_range(0, 3) != 0);
                cc = ($urandom_range(0, 79) == 0);
                dd = ($urandom_range(0, 9) == 0) ? 6'($urandom) : cur[k];
                step(k, vv, dd, cc);
                check_inst(k, "rnd");
                if (vv && !cc) cur[k] = tnext(k, cur[k]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
